bbox_pixel_walker: RTL
======================

// Module: bbox_pixel_walker
// PURPOSE
//   Consumer of the triangle bounding box (XMIN/XMAX/YMIN/YMAX, Q10.6, already rounded to whole pixels).
//   Clips the box to the screen, then walks every pixel in it in row-major order.
//   Emits one pixel coordinate per cycle over a valid/ready stream to the edge-function/shading stage.
//   One box is in flight at a time; the next box is accepted once the current walk finishes.
// PARAMETERS
//   WIDTH     16   coordinate width, fixed point
//   FRAC      6    fractional bits; pixel step = 1<<FRAC
//   SCREEN_W  320  screen width in pixels; x clip limit = (SCREEN_W-1)<<FRAC
//   SCREEN_H  240  screen height in pixels; y clip limit = (SCREEN_H-1)<<FRAC
// PORTS
//   CLK         in   1      single clock, rising edge
//   RST_N       in   1      asynchronous, active-low reset
//   BB_VALID    in   1      bounding box valid
//   BB_READY    out  1      block accepts a box; transfer on BB_VALID&BB_READY at the CLK edge
//   XMIN, XMAX  in   WIDTH  box x bounds, Q10.6, unsigned
//   YMIN, YMAX  in   WIDTH  box y bounds, Q10.6, unsigned
//   PX_VALID    out  1      pixel output valid
//   PX_READY    in   1      downstream accepts pixel
//   PX_X, PX_Y  out  WIDTH  pixel coordinate, Q10.6
//   PX_ROW_END  out  1      qualifies PX_*: pixel is last in its row (x == clipped xmax)
//   PX_LAST     out  1      qualifies PX_*: last pixel of the box
//   DONE        out  1      one-cycle pulse when a box is finished, walked or rejected as empty
// BEHAVIOUR
//   - Reset: all outputs 0 except BB_READY=1; FSM=IDLE; captured box regs 0.
//   - FSM states: IDLE -> CLIP -> WALK -> IDLE.
//     - IDLE: BB_READY=1. On handshake, capture the box with low FRAC bits forced to 0 (floor). Go to CLIP.
//     - CLIP (1 cycle): xmax' = min(XMAX, x limit); ymax' = min(YMAX, y limit).
//       - If XMIN > xmax' or YMIN > ymax': empty box; go to IDLE, DONE=1 on the next cycle, no pixels emitted.
//       - Else load x=XMIN, y=YMIN and go to WALK.
//     - WALK: PX_VALID=1. On PX_VALID&PX_READY, advance:
//       - if x != xmax': x += step;
//       - else if y != ymax': x = XMIN, y += step;
//       - else go to IDLE with DONE=1 for exactly one cycle (the first IDLE cycle).
//   - Latency: box handshake at edge n -> first PX_VALID in cycle n+2. Throughput is 1 pixel/cycle with PX_READY held high.
//   - Backpressure: while PX_VALID & !PX_READY, PX_X/PX_Y/PX_ROW_END/PX_LAST hold stable. PX_VALID never drops before its handshake.
//   - Pixel count = ((xmax'-XMIN)>>FRAC + 1) * ((ymax'-YMIN)>>FRAC + 1).
//   - Compare end conditions for equality against the clipped bounds. The clip keeps x+step <= 0xFFFF, so counters never wrap.
//   - DONE and BB_READY are both high in the first IDLE cycle, so a back-to-back box can be accepted that cycle.
//   - BB_READY=0 in CLIP and WALK. Box inputs are ignored outside IDLE.
//   - Reset mid-walk: outputs clear immediately and asynchronously. The current box is dropped with no DONE. Resume in IDLE.
// CONFIGURATION
//   PIXEL_CENTER_EN
//     - defined: PX_X/PX_Y = walk coordinate + (1<<(FRAC-1)), i.e. sample at the pixel centre (+0x0020).
//     - undefined: PX_X/PX_Y = walk coordinate exactly (low FRAC bits 0).
//     - Internal counters, clipping and pixel count are identical in both builds.
// TESTING
//   1. Box X 0x0080..0x0100, Y 0x0040..0x0080, PX_READY=1 -> 6 pixels:
//      (0080,0040)(00C0,0040)(0100,0040)(0080,0080)(00C0,0080)(0100,0080).
//      ROW_END on the 3rd and 6th pixel; LAST on the 6th; first PX_VALID 2 cycles after accept; DONE 1 cycle after the last handshake.
//   2. Same box, PX_READY toggled pseudo-randomly -> identical 6-pixel sequence; outputs stable during every stall cycle.
//   3. XMIN=XMAX=YMIN=YMAX=0x0140 -> exactly one pixel (0140,0140) with ROW_END=LAST=1, then DONE.
//   4. Clip cases:
//      - XMIN=0x4E00, XMAX=0x7FC0, Y 0x0000..0x0000 -> x runs 0x4E00..0x4FC0 (8 pixels), last x=319.
//      - XMIN=0x5000 -> no PX_VALID; DONE 2 cycles after accept; BB_READY high in the same cycle.
//   5. Assert RST_N=0 after the 3rd handshake of test 1 -> PX_VALID=0, DONE=0, BB_READY=1 immediately. After release, rerun test 1 -> full correct sequence.
//   6. Build with PIXEL_CENTER_EN, rerun test 1 -> first pixel (00A0,0060), last (0120,00A0); count and flags unchanged.

Source files
------------

// File: rtl/bbox_pixel_walker.sv
// rtl/bbox_pixel_walker.sv - clips a Q10.6 bounding box to the screen and walks its pixels in row-major order
// Optional build macro: PIXEL_CENTER_EN (emit pixel-centre sample coordinates)
module bbox_pixel_walker #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 6,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bb_valid_i,
  output logic             bb_ready_o,
  input  logic [WIDTH-1:0] xmin_i,
  input  logic [WIDTH-1:0] xmax_i,
  input  logic [WIDTH-1:0] ymin_i,
  input  logic [WIDTH-1:0] ymax_i,
  output logic             px_valid_o,
  input  logic             px_ready_i,
  output logic [WIDTH-1:0] px_x_o,
  output logic [WIDTH-1:0] px_y_o,
  output logic             px_row_end_o,
  output logic             px_last_o,
  output logic             done_o
);

  // One pixel in fixed point, and the mask that floors a coordinate to a whole pixel
  localparam logic [WIDTH-1:0] STEP       = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [WIDTH-1:0] FLOOR_MASK = {WIDTH{1'b1}} << FRAC;

  // Last addressable pixel on each axis; clipping to these also keeps x+STEP from wrapping
  localparam logic [WIDTH-1:0] X_LIMIT = WIDTH'(SCREEN_W - 1) << FRAC;
  localparam logic [WIDTH-1:0] Y_LIMIT = WIDTH'(SCREEN_H - 1) << FRAC;

`ifdef PIXEL_CENTER_EN
  localparam logic [WIDTH-1:0] CENTER_OFS = STEP >> 1;
`else
  localparam logic [WIDTH-1:0] CENTER_OFS = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_WALK = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Captured box; xmax/ymax are overwritten with the clipped bounds in CLIP
  logic [WIDTH-1:0] xmin_q, xmin_d;
  logic [WIDTH-1:0] xmax_q, xmax_d;
  logic [WIDTH-1:0] ymin_q, ymin_d;
  logic [WIDTH-1:0] ymax_q, ymax_d;

  // Walk position (pixel corner, low FRAC bits always zero)
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic done_q, done_d;

  logic [WIDTH-1:0] xmax_clip;
  logic [WIDTH-1:0] ymax_clip;
  logic             box_empty;
  logic             x_at_end;
  logic             y_at_end;
  logic             walking;

  // Clip the captured upper bounds to the screen and detect a box with no pixels left
  always_comb begin
    xmax_clip = (xmax_q > X_LIMIT) ? X_LIMIT : xmax_q;
    ymax_clip = (ymax_q > Y_LIMIT) ? Y_LIMIT : ymax_q;
    box_empty = (xmin_q > xmax_clip) || (ymin_q > ymax_clip);
  end

  // End-of-row / end-of-box tests are equality against the already clipped bounds
  always_comb begin
    walking  = (state_q == S_WALK);
    x_at_end = (x_q == xmax_q);
    y_at_end = (y_q == ymax_q);
  end

  // Next-state logic: capture, clip, then advance the walk on each accepted pixel
  always_comb begin
    state_d = state_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bb_valid_i) begin
          xmin_d  = xmin_i & FLOOR_MASK;
          xmax_d  = xmax_i & FLOOR_MASK;
          ymin_d  = ymin_i & FLOOR_MASK;
          ymax_d  = ymax_i & FLOOR_MASK;
          state_d = S_CLIP;
        end
      end

      S_CLIP: begin
        xmax_d = xmax_clip;
        ymax_d = ymax_clip;
        if (box_empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          x_d     = xmin_q;
          y_d     = ymin_q;
          state_d = S_WALK;
        end
      end

      S_WALK: begin
        if (px_ready_i) begin
          if (!x_at_end) begin
            x_d = x_q + STEP;
          end else if (!y_at_end) begin
            x_d = xmin_q;
            y_d = y_q + STEP;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any box in flight without a DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  // Pixel outputs are forced to zero outside WALK so they read 0 after reset in every build;
  // inside WALK they come straight from registers and therefore hold during stalls
  always_comb begin
    bb_ready_o   = (state_q == S_IDLE);
    px_valid_o   = walking;
    px_x_o       = walking ? (x_q + CENTER_OFS) : '0;
    px_y_o       = walking ? (y_q + CENTER_OFS) : '0;
    px_row_end_o = walking && x_at_end;
    px_last_o    = walking && x_at_end && y_at_end;
    done_o       = done_q;
  end

endmodule
